shift_reg_ctrl: RTL and testbench
=================================

Name: shift_reg_ctrl

Overview:
Parametrised multi-mode register that generalises the single-bit D flip-flop to WIDTH bits. Supports per-cycle ops: hold, parallel load, logical/arithmetic shift, rotate, and synchronous clear. Also provides an automated N-step shift sequencer with BUSY/DONE. Used as a general datapath register, and as a serialiser/deserialiser front end in the same designs that use the plain flip-flop.

Parameters:
WIDTH, 8, register width in bits (>=2)
SHAMT_W, 4, width of the SHAMT step-count input
RESET_VAL, 0, value loaded into Q by RESET and by the CLEAR op (WIDTH bits)

Ports:
CLK  input  1  clock, rising edge
RESET  input  1  asynchronous reset, active high
EN  input  1  clock enable; when 0, no state changes (Q, counter, FSM hold)
MODE  input  3  op select: 000 HOLD, 001 LOAD, 010 SHL, 011 SHR, 100 ROL, 101 ROR, 110 ASR, 111 CLEAR
D  input  WIDTH  parallel load data
SIN_LSB  input  1  serial bit inserted at Q[0] on SHL
SIN_MSB  input  1  serial bit inserted at Q[WIDTH-1] on SHR
START  input  1  launch sequenced op (sampled only when EN=1 and FSM idle)
SHAMT  input  SHAMT_W  number of steps for the sequenced op
Q  output  WIDTH  register contents
SOUT_MSB  output  1  Q[WIDTH-1], combinational from Q
SOUT_LSB  output  1  Q[0], combinational from Q
BUSY  output  1  sequencer active
DONE  output  1  one-cycle pulse on sequence completion

Behaviour:
- Reset (asynchronous, active high; clock CLK): Q=RESET_VAL, BUSY=0, DONE=0, FSM=IDLE, step counter=0. RESET asserted mid-sequence aborts the sequence with no DONE pulse.
- Op definitions (per enabled edge):
  - HOLD: Q unchanged.
  - LOAD: Q<=D.
  - SHL: Q<={Q[W-2:0],SIN_LSB}.
  - SHR: Q<={SIN_MSB,Q[W-1:1]}.
  - ROL: Q<={Q[W-2:0],Q[W-1]}.
  - ROR: Q<={Q[0],Q[W-1:1]}.
  - ASR: Q<={Q[W-1],Q[W-1:1]}.
  - CLEAR: Q<=RESET_VAL.
- FSM states: IDLE, SHIFT.
- IDLE, EN=1, START=0: MODE op applied at every edge. DONE=0.
- IDLE, EN=1, START=1, accepted at edge t:
  - MODE is latched into an internal register. SHAMT is latched as N.
  - N=0: Q unchanged. DONE=1 for the cycle after edge t. Stay IDLE. BUSY stays 0.
  - N>=1: the latched op is applied once at edge t. Counter<=N-1.
    - If N-1=0: stay IDLE, DONE=1 after edge t.
    - Else: go to SHIFT, BUSY=1 after edge t.
  - Any MODE may be sequenced. LOAD/CLEAR/HOLD repeated N times are legal; the result equals a single application.
- SHIFT: each edge with EN=1 applies the latched op and decrements the counter.
  - The edge at which the counter goes 1->0 is the last step. At that edge: FSM->IDLE, BUSY<=0, DONE<=1 for exactly one cycle.
  - Total steps executed = N. DONE follows the edge of the Nth step.
- SHIFT, EN=0: stall. Q, counter and BUSY hold. No step is lost.
- SHIFT: MODE, START, D, SHAMT inputs are ignored. SIN_LSB/SIN_MSB are sampled live on every step.
- DONE is registered and deasserts on the next enabled edge. It also deasserts on the next edge if EN=0, so the pulse is always one cycle.
- START held high continuously: a new sequence is accepted on the first enabled IDLE edge after completion, which is the same edge at which DONE is visible.
- Widths: SHAMT > WIDTH is legal. Rotates wrap modulo WIDTH naturally. Shifts fill with serial input / sign bit.

Test Plan:
- Reset: RESET=1 mid-run with RESET_VAL=8'hA5 -> Q=A5, BUSY=0, DONE=0 immediately, without a clock edge.
- Direct ops (W=8), each step EN=1:
  - LOAD D=8'h96 -> Q=96.
  - SHL SIN_LSB=1 -> Q=2D.
  - ROR -> Q=96.
  - ASR -> Q=CB.
  - SHR SIN_MSB=0 -> Q=65.
  - CLEAR -> Q=RESET_VAL.
- Sequenced ROL: Q=8'h81, START MODE=ROL SHAMT=3 -> BUSY high for 2 cycles, Q=03,06,0C over successive edges. DONE pulses 1 cycle after the third step. Final Q=0C.
- Stall: same sequence with EN=0 for 2 cycles inside SHIFT -> Q/BUSY frozen during the stall. Final Q=0C. DONE delayed by exactly 2 cycles.
- Boundaries:
  - SHAMT=0 -> Q unchanged, DONE pulse next cycle, BUSY never 1.
  - SHAMT=1 ASR on 8'h80 -> Q=C0, DONE next cycle, BUSY never 1.
  - SHAMT=9 ROL on 8'h01 -> Q=02.
- Ignored inputs: in SHIFT, toggle MODE to LOAD and pulse START -> no effect. Original sequence completes with correct Q and a single DONE.

Source files
------------

// File: rtl/shift_reg_ctrl.sv
// Purpose: WIDTH-bit multi-mode register (hold/load/shift/rotate/clear) with an N-step shift sequencer.
// Latency: direct ops take effect at the next enabled edge; a sequence of N steps finishes at its Nth enabled edge, DONE follows.
// Backpressure: none; EN=0 freezes Q, the step counter and the FSM, and stretches a running sequence.
//
// Ports:
//   CLK, RESET          clock (rising edge), asynchronous active-high reset
//   EN                  clock enable for all state except DONE, which always clears after one cycle
//   MODE[2:0]           op select (HOLD, LOAD, SHL, SHR, ROL, ROR, ASR, CLEAR)
//   D                   parallel load data
//   SIN_LSB / SIN_MSB   serial inputs for SHL / SHR, sampled live on every step
//   START, SHAMT        launch an N=SHAMT step sequence of MODE from IDLE
//   Q                   register contents; SOUT_MSB / SOUT_LSB are its end bits
//   BUSY                sequencer is in SHIFT
//   DONE                one-cycle pulse after the last step (or after an N=0 request)
module shift_reg_ctrl #(
    parameter int               WIDTH     = 8,
    parameter int               SHAMT_W   = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               EN,
    input  logic [2:0]         MODE,
    input  logic [WIDTH-1:0]   D,
    input  logic               SIN_LSB,
    input  logic               SIN_MSB,
    input  logic               START,
    input  logic [SHAMT_W-1:0] SHAMT,
    output logic [WIDTH-1:0]   Q,
    output logic               SOUT_MSB,
    output logic               SOUT_LSB,
    output logic               BUSY,
    output logic               DONE
);

    localparam logic [2:0] OP_HOLD  = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_SHL   = 3'b010;
    localparam logic [2:0] OP_SHR   = 3'b011;
    localparam logic [2:0] OP_ROL   = 3'b100;
    localparam logic [2:0] OP_ROR   = 3'b101;
    localparam logic [2:0] OP_ASR   = 3'b110;
    localparam logic [2:0] OP_CLEAR = 3'b111;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_n;
    logic [SHAMT_W-1:0] cnt_q, cnt_n;
    logic [2:0]         op_q, op_n;
    logic [WIDTH-1:0]   q_q, q_n;
    logic               done_q, done_n;

    function automatic logic [WIDTH-1:0] apply_op(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] q,
        input logic [WIDTH-1:0] d,
        input logic             sin_lsb,
        input logic             sin_msb
    );
        logic [WIDTH-1:0] r;
        case (op)
            OP_HOLD:  r = q;
            OP_LOAD:  r = d;
            OP_SHL:   r = {q[WIDTH-2:0], sin_lsb};
            OP_SHR:   r = {sin_msb, q[WIDTH-1:1]};
            OP_ROL:   r = {q[WIDTH-2:0], q[WIDTH-1]};
            OP_ROR:   r = {q[0], q[WIDTH-1:1]};
            OP_ASR:   r = {q[WIDTH-1], q[WIDTH-1:1]};
            OP_CLEAR: r = RESET_VAL;
            default:  r = q;
        endcase
        return r;
    endfunction

    // State register: FSM plus datapath registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_HOLD;
            q_q     <= RESET_VAL;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            op_q    <= op_n;
            q_q     <= q_n;
            done_q  <= done_n;
        end
    end

    // Next-state logic. DONE defaults low regardless of EN so the pulse is
    // never stretched by a stall.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        op_n    = op_q;
        q_n     = q_q;
        done_n  = 1'b0;
        if (EN) begin
            case (state_q)
                ST_IDLE: begin
                    if (START) begin
                        op_n = MODE;
                        if (SHAMT == '0) begin
                            done_n = 1'b1;
                        end else begin
                            // First step happens on the accepting edge itself.
                            q_n   = apply_op(MODE, q_q, D, SIN_LSB, SIN_MSB);
                            cnt_n = SHAMT - 1'b1;
                            if (SHAMT == SHAMT_W'(1)) begin
                                done_n = 1'b1;
                            end else begin
                                state_n = ST_SHIFT;
                            end
                        end
                    end else begin
                        q_n = apply_op(MODE, q_q, D, SIN_LSB, SIN_MSB);
                    end
                end
                ST_SHIFT: begin
                    // MODE/START/D/SHAMT are ignored here; serial inputs stay live.
                    q_n   = apply_op(op_q, q_q, D, SIN_LSB, SIN_MSB);
                    cnt_n = cnt_q - 1'b1;
                    if (cnt_q == SHAMT_W'(1)) begin
                        state_n = ST_IDLE;
                        done_n  = 1'b1;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // Output logic.
    always_comb begin
        Q        = q_q;
        SOUT_MSB = q_q[WIDTH-1];
        SOUT_LSB = q_q[0];
        BUSY     = (state_q == ST_SHIFT);
        DONE     = done_q;
    end

endmodule

// File: tb/tb_shift_reg_ctrl.sv
module tb_shift_reg_ctrl;

    localparam int         W   = 8;
    localparam logic [7:0] RV  = 8'hA5;

    localparam int HOLD = 0, LOAD = 1, SHL = 2, SHR = 3, ROL = 4, ROR = 5, ASR = 6, CLR = 7;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       EN;
    logic [2:0] MODE;
    logic [7:0] D;
    logic       SIN_LSB, SIN_MSB, START;
    logic [3:0] SHAMT;
    logic [7:0] Q;
    logic       SOUT_MSB, SOUT_LSB, BUSY, DONE;

    shift_reg_ctrl #(.WIDTH(W), .SHAMT_W(4), .RESET_VAL(RV)) dut (
        .CLK(CLK), .RESET(RESET), .EN(EN), .MODE(MODE), .D(D),
        .SIN_LSB(SIN_LSB), .SIN_MSB(SIN_MSB), .START(START), .SHAMT(SHAMT),
        .Q(Q), .SOUT_MSB(SOUT_MSB), .SOUT_LSB(SOUT_LSB), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int q;
        bit busy;
        bit done;
    } exp_t;

    exp_t  sb[$];
    string lq[$];
    int    total = 0;
    int    bad   = 0;

    // Reference model: register value as an integer 0..255, plus the
    // number of steps still owed by a running sequence.
    int m_q    = RV;
    int m_left = 0;
    int m_op   = HOLD;

    function automatic int ref_op(int op, int q, int d, int sl, int sm);
        case (op)
            LOAD:    return d;
            SHL:     return (q * 2) % 256 + sl;
            SHR:     return q / 2 + sm * 128;
            ROL:     return (q * 2) % 256 + q / 128;
            ROR:     return q / 2 + (q % 2) * 128;
            ASR:     return q / 2 + (q / 128) * 128;
            CLR:     return RV;
            default: return q;
        endcase
    endfunction

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // Monitor: the DUT presents a fresh Q/BUSY/DONE after every edge.
    always @(negedge CLK) begin
        if (sb.size() > 0) begin
            exp_t  e;
            string t;
            e = sb.pop_front();
            t = lq.pop_front();
            total++;
            if (Q !== e.q[7:0] || BUSY !== e.busy || DONE !== e.done ||
                SOUT_MSB !== e.q[7] || SOUT_LSB !== e.q[0]) begin
                bad++;
                $display("FAIL %s: got q=%h busy=%b done=%b smsb=%b slsb=%b, expected q=%h busy=%b done=%b",
                         t, Q, BUSY, DONE, SOUT_MSB, SOUT_LSB, e.q[7:0], e.busy, e.done);
            end
        end
    end

    task automatic cyc(input bit en, input int mode, input int d, input bit sl, input bit sm,
                       input bit st, input int sh, input string tag);
        exp_t e;
        bit   dn;
        EN = en; MODE = mode[2:0]; D = d[7:0]; SIN_LSB = sl; SIN_MSB = sm;
        START = st; SHAMT = sh[3:0];
        dn = 1'b0;
        if (en) begin
            if (m_left == 0) begin
                if (st) begin
                    m_op = mode;
                    if (sh == 0) begin
                        dn = 1'b1;
                    end else begin
                        m_q    = ref_op(mode, m_q, d, sl, sm);
                        m_left = sh - 1;
                        dn     = (m_left == 0);
                    end
                end else begin
                    m_q = ref_op(mode, m_q, d, sl, sm);
                end
            end else begin
                m_q = ref_op(m_op, m_q, d, sl, sm);
                m_left--;
                dn = (m_left == 0);
            end
        end
        e.q = m_q; e.busy = (m_left > 0); e.done = dn;
        @(posedge CLK);
        sb.push_back(e);
        lq.push_back(tag);
        #1;
    endtask

    task automatic op(input int mode, input int d, input bit sl, input bit sm, input string tag);
        cyc(1'b1, mode, d, sl, sm, 1'b0, 0, tag);
    endtask

    task automatic reset_now(input string tag);
        @(negedge CLK);
        #1;
        RESET = 1'b1;
        #1;
        check({tag, "_q"}, int'(Q), int'(RV));
        check({tag, "_busy"}, int'(BUSY), 0);
        check({tag, "_done"}, int'(DONE), 0);
        m_q = RV; m_left = 0; m_op = HOLD;
        #1;
        RESET = 1'b0;
    endtask

    initial begin
        RESET = 1'b1; EN = 1'b0; MODE = 3'd0; D = 8'h00;
        SIN_LSB = 1'b0; SIN_MSB = 1'b0; START = 1'b0; SHAMT = 4'd0;
        #2;
        check("por_q", int'(Q), int'(RV));
        check("por_busy", int'(BUSY), 0);
        check("por_done", int'(DONE), 0);
        #1 RESET = 1'b0;

        // Direct ops.
        op(LOAD, 'h96, 0, 0, "load96");
        op(SHL,  0,    1, 0, "shl");
        op(ROR,  0,    0, 0, "ror");
        op(ASR,  0,    0, 0, "asr");
        op(SHR,  0,    0, 0, "shr");
        op(CLR,  0,    0, 0, "clear");

        // Sequenced ROL x3 from 81.
        op(LOAD, 'h81, 0, 0, "seq_load");
        cyc(1, ROL, 0, 0, 0, 1, 3, "seq_s1");
        cyc(1, HOLD, 0, 0, 0, 0, 0, "seq_s2");
        cyc(1, HOLD, 0, 0, 0, 0, 0, "seq_s3");
        cyc(1, HOLD, 0, 0, 0, 0, 0, "seq_done");
        cyc(1, HOLD, 0, 0, 0, 0, 0, "seq_after");

        // Same sequence with a two-cycle stall inside SHIFT.
        op(LOAD, 'h81, 0, 0, "stall_load");
        cyc(1, ROL, 0, 0, 0, 1, 3, "stall_s1");
        cyc(0, HOLD, 0, 0, 0, 0, 0, "stall_e0a");
        cyc(0, HOLD, 0, 0, 0, 0, 0, "stall_e0b");
        cyc(1, HOLD, 0, 0, 0, 0, 0, "stall_s2");
        cyc(1, HOLD, 0, 0, 0, 0, 0, "stall_s3");
        cyc(1, HOLD, 0, 0, 0, 0, 0, "stall_done");

        // Boundaries.
        op(LOAD, 'h5A, 0, 0, "n0_load");
        cyc(1, ROL, 0, 0, 0, 1, 0, "n0_start");
        cyc(1, HOLD, 0, 0, 0, 0, 0, "n0_after");
        op(LOAD, 'h80, 0, 0, "n1_load");
        cyc(1, ASR, 0, 0, 0, 1, 1, "n1_asr");
        cyc(1, HOLD, 0, 0, 0, 0, 0, "n1_after");
        op(LOAD, 'h01, 0, 0, "n9_load");
        cyc(1, ROL, 0, 0, 0, 1, 9, "n9_start");
        for (int i = 0; i < 9; i++) cyc(1, HOLD, 0, 0, 0, 0, 0, "n9_run");

        // Ignored inputs while in SHIFT.
        op(LOAD, 'h81, 0, 0, "ign_load");
        cyc(1, ROL, 0, 0, 0, 1, 3, "ign_s1");
        cyc(1, LOAD, 'hFF, 0, 0, 1, 7, "ign_s2");
        cyc(1, LOAD, 'hFF, 0, 0, 1, 7, "ign_s3");
        cyc(1, HOLD, 0, 0, 0, 0, 0, "ign_done");
        cyc(1, HOLD, 0, 0, 0, 0, 0, "ign_after");

        // START held high: back-to-back sequences.
        op(LOAD, 'h01, 0, 0, "b2b_load");
        for (int i = 0; i < 6; i++) cyc(1, ROL, 0, 0, 0, 1, 2, "b2b");
        cyc(1, HOLD, 0, 0, 0, 0, 0, "b2b_end");
        cyc(1, HOLD, 0, 0, 0, 0, 0, "b2b_end2");

        // Reset in the middle of a sequence: no DONE afterwards.
        op(LOAD, 'h3C, 0, 0, "abort_load");
        cyc(1, SHL, 0, 1, 0, 1, 5, "abort_s1");
        cyc(1, HOLD, 0, 0, 0, 0, 0, "abort_s2");
        reset_now("abort_rst");
        cyc(1, HOLD, 0, 0, 0, 0, 0, "abort_after1");
        cyc(1, HOLD, 0, 0, 0, 0, 0, "abort_after2");

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 9) < 8), int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                ($urandom_range(0, 4) == 0), int'($urandom_range(0, 12)), "rand");
        end

        @(negedge CLK);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
